// File: rtl/clock_lock_supervisor.sv
// clock_lock_supervisor
// Brings the pixel-clock MMCM from power-up to a stable running state and
// keeps it there. It pulses the MMCM reset, waits for LOCKED, and releases the
// downstream pixel-domain reset only once lock has held for STABLE_CYCLES.
// A lock timeout triggers a retry, and after MAX_RETRIES timeouts the block
// parks in FAIL. A loss of lock in RUN restarts the whole sequence.
//
// Ports
//   clk          free-running reference clock (100 MHz)
//   rst_n        asynchronous active-low reset
//   mmcm_locked  MMCM LOCKED, asynchronous to clk
//   restart      single-cycle request to restart the sequence (highest priority)
//   mmcm_rst     MMCM reset, active high
//   sys_rst_n    downstream pixel-domain reset, active low
//   running      high only in RUN
//   fail         high only in FAIL
//   state        current state code
//   retry_cnt    lock timeouts in the current attempt series
//   loss_cnt     lock losses seen in RUN, saturating at 255
//
// state      | meaning
// -----------+------------------------------------------------------------
// RESET_HOLD | MMCM held in reset for RST_CYCLES
// WAIT_LOCK  | MMCM released, waiting up to LOCK_TIMEOUT for locked_s
// STABLE     | lock seen, must hold for STABLE_CYCLES consecutive cycles
// RUN        | downstream reset released, watching for loss of lock
// FAIL       | too many timeouts, parked until restart or rst_n
module clock_lock_supervisor #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 1000,
  parameter int STABLE_CYCLES = 64,
  parameter int MAX_RETRIES   = 3,
  parameter int CNT_W         = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mmcm_locked,
  input  logic       restart,
  output logic       mmcm_rst,
  output logic       sys_rst_n,
  output logic       running,
  output logic       fail,
  output logic [2:0] state,
  output logic [3:0] retry_cnt,
  output logic [7:0] loss_cnt
);

  typedef enum logic [2:0] {
    RESET_HOLD = 3'd0,
    WAIT_LOCK  = 3'd1,
    STABLE     = 3'd2,
    RUN        = 3'd3,
    FAIL       = 3'd4
  } state_t;

  // The timer starts at 0 on state entry, so the last cycle of a phase of
  // N cycles is the one where the timer reads N-1.
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_MAX   = 4'(MAX_RETRIES);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [3:0]       retry_d;
  logic [7:0]       loss_d;
  logic             sync_q, locked_s;

  // Two-flop synchroniser; nothing downstream looks at mmcm_locked directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync_q   <= mmcm_locked;
      locked_s <= sync_q;
    end
  end

  always_comb begin
    state_d = state_q;
    retry_d = retry_cnt;
    loss_d  = loss_cnt;
    if (restart) begin
      state_d = RESET_HOLD;
      retry_d = '0;
    end else begin
      case (state_q)
        RESET_HOLD: if (timer_q == RST_LAST) state_d = WAIT_LOCK;
        WAIT_LOCK: begin
          // Lock wins over a timeout landing on the same cycle.
          if (locked_s) begin
            state_d = STABLE;
          end else if (timer_q == LOCK_LAST) begin
            retry_d = retry_cnt + 4'd1;
            state_d = (retry_d == RETRY_MAX) ? FAIL : RESET_HOLD;
          end
        end
        STABLE: begin
          if (!locked_s) begin
            state_d = WAIT_LOCK;
          end else if (timer_q == STABLE_LAST) begin
            state_d = RUN;
            retry_d = '0;
          end
        end
        RUN: begin
          if (!locked_s) begin
            state_d = RESET_HOLD;
            if (loss_cnt != 8'hFF) loss_d = loss_cnt + 8'd1;
          end
        end
        FAIL: state_d = FAIL;
        default: state_d = RESET_HOLD;
      endcase
    end
    // A held restart re-enters RESET_HOLD every cycle, pinning the timer at 0.
    timer_d = (restart || (state_d != state_q)) ? '0 : timer_q + CNT_W'(1);
  end

  // Outputs are decoded from the next state so they change on the same edge
  // as the state register; sys_rst_n drops on the edge that leaves RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RESET_HOLD;
      timer_q   <= '0;
      retry_cnt <= '0;
      loss_cnt  <= '0;
      mmcm_rst  <= 1'b1;
      sys_rst_n <= 1'b0;
      running   <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      retry_cnt <= retry_d;
      loss_cnt  <= loss_d;
      mmcm_rst  <= (state_d == RESET_HOLD) || (state_d == FAIL);
      sys_rst_n <= (state_d == RUN);
      running   <= (state_d == RUN);
      fail      <= (state_d == FAIL);
    end
  end

  assign state = state_q;

endmodule

// File: doc/clock_lock_supervisor.md
Name: clock_lock_supervisor

Overview:
Sequences the pixel-clock MMCM from power-up to a stable running state, and keeps it there.
- Drives the MMCM reset and monitors the asynchronous LOCKED signal.
- Releases the downstream pixel-domain reset only after lock has been stable for a set time.
- Retries after a lock timeout and recovers from loss of lock.
- Runs on the free-running 100 MHz input clock, beside the clock generator, and feeds the video pipeline reset tree.

Parameters:
RST_CYCLES, 16, cycles mmcm_rst is held high per attempt (>=1)
LOCK_TIMEOUT, 1000, cycles allowed in WAIT_LOCK before declaring timeout (>=1)
STABLE_CYCLES, 64, consecutive synced-locked cycles required before RUN (>=1)
MAX_RETRIES, 3, timeouts tolerated before FAIL (1..15)
CNT_W, 16, width of the shared phase timer; must hold max of the three cycle parameters

Ports:
clk  in  1  free-running reference clock (100 MHz)
rst_n  in  1  asynchronous active-low reset
mmcm_locked  in  1  MMCM LOCKED, asynchronous to clk
restart  in  1  synchronous single-cycle request to restart the sequence
mmcm_rst  out  1  MMCM reset, active high
sys_rst_n  out  1  downstream reset, active low
running  out  1  high only in RUN
fail  out  1  high only in FAIL
state  out  3  current state code
retry_cnt  out  4  timeouts in the current attempt series
loss_cnt  out  8  lock losses seen in RUN, saturating

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- During reset, all flops take their reset value. After reset, the block enters RESET_HOLD.
- Reset values: mmcm_rst=1, sys_rst_n=0, running=0, fail=0, state=0, retry_cnt=0, loss_cnt=0, timer=0, sync flops=0.
- mmcm_locked passes through a 2-flop synchroniser giving locked_s. Latency is 2 cycles, and all decisions use locked_s only.
- All outputs are registered and reflect the current state.
- State codes: RESET_HOLD=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4. Codes 5-7 are illegal and go to RESET_HOLD.
- The timer clears on every state entry and increments each cycle within a state.
- RESET_HOLD: mmcm_rst=1, sys_rst_n=0. After exactly RST_CYCLES cycles in the state, go to WAIT_LOCK.
- WAIT_LOCK: mmcm_rst=0, sys_rst_n=0.
  - locked_s=1 → STABLE.
  - Otherwise, after LOCK_TIMEOUT cycles, retry_cnt increments. If the new value equals MAX_RETRIES → FAIL, else → RESET_HOLD.
  - If lock and timeout occur in the same cycle, lock wins.
- STABLE: mmcm_rst=0, sys_rst_n=0.
  - locked_s=0 → WAIT_LOCK. The timer restarts and retry_cnt is unchanged.
  - After STABLE_CYCLES consecutive cycles with locked_s=1 → RUN, and retry_cnt clears.
- RUN: mmcm_rst=0, sys_rst_n=1, running=1.
  - locked_s=0 → RESET_HOLD; sys_rst_n goes low on that same clock edge.
  - loss_cnt increments on that edge, saturating at 255.
- FAIL: mmcm_rst=1, sys_rst_n=0, fail=1. Exits only via restart or rst_n.
- restart=1 in any state has highest priority:
  - next state is RESET_HOLD;
  - retry_cnt, timer and fail clear;
  - loss_cnt is preserved.
  - restart held high keeps the block in RESET_HOLD with the timer at 0.
- sys_rst_n is never high unless the state is RUN. mmcm_rst and sys_rst_n are never both released outside RUN.
- Glitches on mmcm_locked shorter than one clk period may be missed; no filtering beyond STABLE_CYCLES.

Test Plan:
- Power-up, clean lock: release rst_n and raise mmcm_locked 50 cycles after mmcm_rst falls.
  - mmcm_rst high for exactly 16 cycles.
  - state 1→2 two cycles after locked rises; RUN/sys_rst_n=1 64 cycles later.
  - retry_cnt=0.
- Timeouts to FAIL: hold mmcm_locked=0.
  - Three 16-cycle RESET_HOLD + 1000-cycle WAIT_LOCK rounds.
  - Then state=4, fail=1, mmcm_rst=1, retry_cnt=3; stays there for 10000 cycles.
- Restart from FAIL: pulse restart, then lock normally.
  - fail=0 next cycle, retry_cnt=0, full sequence to RUN.
- Unstable lock: drop locked for 3 cycles at cycle 40 of STABLE.
  - Return to WAIT_LOCK with retry_cnt unchanged.
  - RUN only after 64 uninterrupted cycles.
- Loss in RUN: drop locked for 1 cycle in RUN.
  - sys_rst_n=0 and state=0 two cycles + one edge later, loss_cnt=1.
  - Re-lock returns to RUN.
  - Repeat 260 times → loss_cnt=255.
- Async reset mid-STABLE: assert rst_n low asynchronously.
  - All outputs at reset values immediately without a clock edge; restart from RESET_HOLD.
